// File: rtl/ks_pkg.sv
// Shared types and elaboration helpers for the pipelined Kogge-Stone adder.
package ks_pkg;

    typedef struct packed {
        logic g;
        logic p;
    } ks_gp_t;

    function automatic int ks_levels(input int width);
        return $clog2(width + 1);
    endfunction

    function automatic int ks_latency(input int width, input int pipe_every);
        if (pipe_every == 0) return 1;
        return 1 + (ks_levels(width) - 1) / pipe_every;
    endfunction

    // True when a stage register follows prefix level `level`.
    function automatic bit ks_is_reg(input int level, input int levels, input int pipe_every);
        if (pipe_every == 0 || level < 1 || level >= levels) return 1'b0;
        return (level % pipe_every) == 0;
    endfunction

endpackage

// File: rtl/ks_prefix_level.sv
// One combinational Kogge-Stone row: black, grey and buffer cells over WIDTH+1 positions.
module ks_prefix_level
    import ks_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int LEVEL = 1
) (
    input  ks_gp_t [WIDTH:0] gp_i,
    output ks_gp_t [WIDTH:0] gp_o
);
    localparam int DIST = 1 << (LEVEL - 1);

    // Index 0 is the carry-in position; index i+1 is operand bit i.
    for (genvar gi = 0; gi <= WIDTH; gi++) begin : g_pos
        if (gi < DIST) begin : g_buf
            assign gp_o[gi] = gp_i[gi];
        end else if (gi < 2 * DIST) begin : g_grey
            assign gp_o[gi] = '{g: gp_i[gi].g | (gp_i[gi].p & gp_i[gi - DIST].g), p: 1'b0};
        end else begin : g_black
            assign gp_o[gi] = '{g: gp_i[gi].g | (gp_i[gi].p & gp_i[gi - DIST].g),
                                p: gp_i[gi].p & gp_i[gi - DIST].p};
        end
    end

endmodule

// File: rtl/ks_pipe_adder.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready flow control.
// Define KS_OVF_EN to add the two's-complement overflow output out_ovf.
module ks_pipe_adder
    import ks_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int PIPE_EVERY = 2,
    parameter int TAG_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic [TAG_W-1:0] out_tag
`ifdef KS_OVF_EN
    ,
    output logic             out_ovf
`endif
);
    localparam int LEVELS = ks_levels(WIDTH);

    logic [LEVELS:0]  down_adv;
    logic [LEVELS:1]  reg_vld;
    logic             out_valid_q;
    logic             out_cout_q;
    logic [WIDTH-1:0] out_sum_q;
    logic [TAG_W-1:0] out_tag_q;

    // down_adv[k]: whatever sits after level k moves into the next register this cycle.
    always_comb begin
        down_adv         = '0;
        down_adv[LEVELS] = !out_valid_q || out_ready;
        for (int k = LEVELS - 1; k >= 0; k--) begin
            if (ks_is_reg(k + 1, LEVELS, PIPE_EVERY))
                down_adv[k] = !reg_vld[k + 1] || down_adv[k + 1];
            else
                down_adv[k] = down_adv[k + 1];
        end
    end

    assign in_ready = down_adv[0];

    for (genvar gi = 0; gi <= LEVELS; gi++) begin : g_lvl
        ks_gp_t [WIDTH:0] gp;
        logic [WIDTH-1:0] p;
        logic [TAG_W-1:0] tag;
        logic             vld;

        if (gi == 0) begin : g_pre
            logic [WIDTH-1:0] b_eff;
            assign b_eff = in_sub ? ~in_b : in_b;
            always_comb begin
                gp    = '0;
                gp[0] = '{g: in_sub ^ in_cin, p: 1'b0};
                for (int i = 0; i < WIDTH; i++)
                    gp[i + 1] = '{g: in_a[i] & b_eff[i], p: in_a[i] ^ b_eff[i]};
            end
            assign p   = in_a ^ b_eff;
            assign tag = in_tag;
            assign vld = in_valid;
        end else begin : g_row
            ks_gp_t [WIDTH:0] gp_d;

            ks_prefix_level #(
                .WIDTH (WIDTH),
                .LEVEL (gi)
            ) u_level (
                .gp_i (g_lvl[gi - 1].gp),
                .gp_o (gp_d)
            );

            if (ks_is_reg(gi, LEVELS, PIPE_EVERY)) begin : g_reg
                ks_gp_t [WIDTH:0] gp_q;
                logic [WIDTH-1:0] p_q;
                logic [TAG_W-1:0] tag_q;
                logic             vld_q;

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        vld_q <= 1'b0;
                        gp_q  <= '0;
                        p_q   <= '0;
                        tag_q <= '0;
                    end else if (down_adv[gi - 1]) begin
                        vld_q <= g_lvl[gi - 1].vld;
                        if (g_lvl[gi - 1].vld) begin
                            gp_q  <= gp_d;
                            p_q   <= g_lvl[gi - 1].p;
                            tag_q <= g_lvl[gi - 1].tag;
                        end
                    end
                end

                assign gp          = gp_q;
                assign p           = p_q;
                assign tag         = tag_q;
                assign vld         = vld_q;
                assign reg_vld[gi] = vld_q;
            end else begin : g_comb
                assign gp          = gp_d;
                assign p           = g_lvl[gi - 1].p;
                assign tag         = g_lvl[gi - 1].tag;
                assign vld         = g_lvl[gi - 1].vld;
                assign reg_vld[gi] = 1'b0;
            end
        end
    end

    ks_gp_t [WIDTH:0] gp_fin;
    logic [WIDTH-1:0] sum_d;
    logic             unused_fin_p;

    assign gp_fin = g_lvl[LEVELS].gp;

    // Index i of the final row is the carry into bit i; index WIDTH is carry-out.
    always_comb begin
        sum_d        = '0;
        unused_fin_p = 1'b0;
        for (int i = 0; i < WIDTH; i++)
            sum_d[i] = g_lvl[LEVELS].p[i] ^ gp_fin[i].g;
        for (int i = 0; i <= WIDTH; i++)
            unused_fin_p = unused_fin_p ^ gp_fin[i].p;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_cout_q  <= 1'b0;
            out_tag_q   <= '0;
        end else if (down_adv[LEVELS]) begin
            out_valid_q <= g_lvl[LEVELS].vld;
            if (g_lvl[LEVELS].vld) begin
                out_sum_q  <= sum_d;
                out_cout_q <= gp_fin[WIDTH].g;
                out_tag_q  <= g_lvl[LEVELS].tag;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_cout  = out_cout_q;
    assign out_tag   = out_tag_q;

`ifdef KS_OVF_EN
    logic out_ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            out_ovf_q <= 1'b0;
        else if (down_adv[LEVELS] && g_lvl[LEVELS].vld)
            out_ovf_q <= gp_fin[WIDTH].g ^ gp_fin[WIDTH - 1].g;
    end

    assign out_ovf = out_ovf_q;
`endif

endmodule
